memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Round-robin arbiter and sequencer that shares one single-ported data-memory interface among three requesters: the instruction fetch unit, the geometry unit and the host/ABI port. It issues one transaction at a time to the memory, selects the owner with a walking-one grant vector, latches the owner's address and data, returns read data with a one-cycle Ack pulse, and aborts a transaction that stalls past a timeout.

## Interface
- ADDR_WIDTH, 16, address width of requesters and memory port
- DATA_WIDTH, 32, data width of requesters and memory port
- TIMEOUT, 1024, MemAck wait limit in cycles; 0 disables the timeout; width 16 bits
- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- Req  in  3  request per requester; bit0 = fetch, bit1 = geometry, bit2 = host
- Addr0, Addr1, Addr2  in  ADDR_WIDTH each  per-requester address
- WData0, WData1, WData2  in  DATA_WIDTH each  per-requester write data
- WE  in  3  per-requester write enable (1 = write, 0 = read)
- Grant  out  3  walking-one owner vector; 000 when idle
- Ack  out  3  one-cycle completion pulse to the owner only
- Error  out  1  one-cycle pulse together with Ack when the transaction timed out
- RData  out  DATA_WIDTH  registered read data, valid in the Ack cycle
- MemAddr  out  ADDR_WIDTH  latched address of the owner
- MemWData  out  DATA_WIDTH  latched write data of the owner
- MemWE  out  1  latched write enable of the owner
- MemReq  out  1  held high until MemAck or timeout
- MemAck  in  1  memory completion strobe; MemRData valid in the same cycle
- MemRData  in  DATA_WIDTH  memory read data

## Operation
- States: IDLE, BUSY, RELEASE. Reset -> IDLE.
- Reset values: Grant=000, Ack=000, Error=0, RData=0, MemAddr=0, MemWData=0, MemWE=0, MemReq=0, timeout counter=0, LastGrant=100, so requester 0 has first priority.
- IDLE: if Req != 000, the block picks the first asserted bit in rotated priority order, starting one position after LastGrant and wrapping 2->0. On the same edge it latches Grant, LastGrant, MemAddr, MemWData and MemWE from the selected requester, sets MemReq=1, clears the counter, and moves to BUSY. If Req=000, it stays in IDLE.
- BUSY: the counter increments every cycle in which MemAck=0.
  - On MemAck=1: RData<=MemRData, Ack<=Grant, MemReq<=0, go to RELEASE.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with MemAck=0: Ack<=Grant, Error<=1, RData keeps its previous value, MemReq<=0, go to RELEASE.
  - MemAck has priority if it coincides with the timeout cycle, so no Error is raised.
- RELEASE: Grant<=000, Ack<=000, Error<=0. Req is ignored in this state so the owner has one cycle to drop its request. The block then goes to IDLE.
- Requester rules: hold Req, Addr, WData and WE stable until Ack. The inputs are latched at grant, so later changes have no effect. If Req drops during BUSY, the transaction still completes and the Ack pulse is still issued.
- Non-owners see Ack=0. Only one Grant bit is ever set.
- MemAck outside BUSY is ignored.
- Reset asserted mid-transaction forces all outputs and state to their reset values asynchronously. MemReq drops without an Ack.

## Timing
- Req sampled high in IDLE at edge N -> Grant and MemReq high after edge N (1-cycle grant latency).
- MemAck high at edge M -> Ack, RData and, on the timeout path, Error are valid for exactly the cycle after edge M. MemReq is low from that cycle.
- RELEASE occupies the cycle after edge M+1. IDLE is reached after edge M+2. The next Grant appears after edge M+3 at the earliest.
- Best-case throughput: one transaction per 4 cycles when MemAck returns in the first BUSY cycle.
- Timeout: Ack and Error are high in the cycle following the TIMEOUT-th BUSY cycle without MemAck.
- Grant is constant from the grant cycle through the Ack cycle. MemAddr, MemWData and MemWE are constant while MemReq=1.

## Test plan
- Reset then single read: Req=001, Addr0=0x0040, MemAck one cycle after MemReq with MemRData=0xDEADBEEF -> Grant=001, MemAddr=0x0040, MemWE=0; Ack=001 and RData=0xDEADBEEF for one cycle; Grant=000 in the next cycle.
- Round-robin fairness: Req=111 held, every requester re-asserts immediately after RELEASE -> grant sequence 001, 010, 100, 001, with no requester granted twice in a row.
- Write path: Req=100, WE=100, Addr2=0x1234, WData2=0x0000CAFE; Addr2 is changed during BUSY -> MemAddr stays 0x1234, MemWData=0x0000CAFE, MemWE=1; Ack=100.
- Timeout: TIMEOUT=8, MemAck never asserted -> Ack=Grant and Error=1 for one cycle after 8 BUSY cycles, RData unchanged, MemReq=0. With MemAck arriving on the 8th cycle, Error=0.
- Async reset mid-BUSY: Reset pulsed between edges -> MemReq, Grant and Ack go to 0 immediately. After release, Req=010 gets Grant=010, because LastGrant is back at 100 and the rotated search from requester 0 finds requester 1 first.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Round-robin sequencer sharing one data-memory port among fetch,
// geometry and host requesters, with an optional MemAck timeout.
module memory_port_arbiter #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] TIMEOUT    = 16'd1024
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [2:0]            Req,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [ADDR_WIDTH-1:0] Addr2,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic [DATA_WIDTH-1:0] WData1,
    input  logic [DATA_WIDTH-1:0] WData2,
    input  logic [2:0]            WE,
    output logic [2:0]            Grant,
    output logic [2:0]            Ack,
    output logic                  Error,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic                  MemWE,
    output logic                  MemReq,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRData
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [2:0]            r_grant;
    logic [2:0]            r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_memreq;
    logic [15:0]           r_cnt;
    logic [2:0]            r_last;

    logic [2:0]            w_grant_d;
    logic [2:0]            w_ack_d;
    logic                  w_err_d;
    logic [DATA_WIDTH-1:0] w_rdata_d;
    logic [ADDR_WIDTH-1:0] w_addr_d;
    logic [DATA_WIDTH-1:0] w_wdata_d;
    logic                  w_we_d;
    logic                  w_memreq_d;
    logic [15:0]           w_cnt_d;
    logic [2:0]            w_last_d;

    logic [2:0]            w_sel;
    logic                  w_any;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [DATA_WIDTH-1:0] w_req_wdata;
    logic                  w_req_we;

    assign w_any = |Req;

    assign w_timeout = (TIMEOUT != 16'd0)
                    && (r_cnt == TIMEOUT - 16'd1)
                    && !MemAck;

    // Search starts one position after the last owner and wraps 2->0.
    always_comb begin
        w_sel = 3'b000;
        unique case (1'b1)
            r_last[0]: begin
                if (Req[1])      w_sel = 3'b010;
                else if (Req[2]) w_sel = 3'b100;
                else if (Req[0]) w_sel = 3'b001;
            end
            r_last[1]: begin
                if (Req[2])      w_sel = 3'b100;
                else if (Req[0]) w_sel = 3'b001;
                else if (Req[1]) w_sel = 3'b010;
            end
            default: begin
                if (Req[0])      w_sel = 3'b001;
                else if (Req[1]) w_sel = 3'b010;
                else if (Req[2]) w_sel = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_req_addr  = Addr0;
        w_req_wdata = WData0;
        w_req_we    = WE[0];
        unique case (1'b1)
            w_sel[1]: begin
                w_req_addr  = Addr1;
                w_req_wdata = WData1;
                w_req_we    = WE[1];
            end
            w_sel[2]: begin
                w_req_addr  = Addr2;
                w_req_wdata = WData2;
                w_req_we    = WE[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // RELEASE spans the Ack cycle and one quiet cycle with Req ignored.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_BUSY;
            end
            S_BUSY: begin
                if (MemAck || w_timeout) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_ack == 3'b000) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_d  = r_grant;
        w_ack_d    = r_ack;
        w_err_d    = r_err;
        w_rdata_d  = r_rdata;
        w_addr_d   = r_addr;
        w_wdata_d  = r_wdata;
        w_we_d     = r_we;
        w_memreq_d = r_memreq;
        w_cnt_d    = r_cnt;
        w_last_d   = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_d  = w_sel;
                    w_last_d   = w_sel;
                    w_addr_d   = w_req_addr;
                    w_wdata_d  = w_req_wdata;
                    w_we_d     = w_req_we;
                    w_memreq_d = 1'b1;
                    w_cnt_d    = 16'd0;
                end
            end
            S_BUSY: begin
                if (MemAck) begin
                    w_rdata_d  = MemRData;
                    w_ack_d    = r_grant;
                    w_memreq_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + 16'd1;
                    if (w_timeout) begin
                        w_ack_d    = r_grant;
                        w_err_d    = 1'b1;
                        w_memreq_d = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                w_grant_d = 3'b000;
                w_ack_d   = 3'b000;
                w_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_grant  <= 3'b000;
            r_ack    <= 3'b000;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_memreq <= 1'b0;
            r_cnt    <= 16'd0;
            r_last   <= 3'b100;
        end else begin
            r_grant  <= w_grant_d;
            r_ack    <= w_ack_d;
            r_err    <= w_err_d;
            r_rdata  <= w_rdata_d;
            r_addr   <= w_addr_d;
            r_wdata  <= w_wdata_d;
            r_we     <= w_we_d;
            r_memreq <= w_memreq_d;
            r_cnt    <= w_cnt_d;
            r_last   <= w_last_d;
        end
    end

    assign Grant    = r_grant;
    assign Ack      = r_ack;
    assign Error    = r_err;
    assign RData    = r_rdata;
    assign MemAddr  = r_addr;
    assign MemWData = r_wdata;
    assign MemWE    = r_we;
    assign MemReq   = r_memreq;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized checks of memory_port_arbiter against a
// transaction-level reference model.
module tb_memory_port_arbiter;

    localparam int TMO = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  Req;
    logic [2:0]  WE;
    logic [15:0] a_addr  [3];
    logic [31:0] a_wdata [3];
    logic        MemAck;
    logic [31:0] MemRData;

    logic [2:0]  Grant;
    logic [2:0]  Ack;
    logic        Error;
    logic [31:0] RData;
    logic [15:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemWE;
    logic        MemReq;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 waiting on memory, 2 wind-down.
    int          m_phase;
    int          m_owner;
    int          m_last;
    int          m_waited;
    int          m_rel;
    bit          m_ack;
    bit          m_err;
    logic [31:0] m_rdata;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    bit          m_memreq;

    memory_port_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .TIMEOUT   (16'(TMO))
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .Addr0   (a_addr[0]),
        .Addr1   (a_addr[1]),
        .Addr2   (a_addr[2]),
        .WData0  (a_wdata[0]),
        .WData1  (a_wdata[1]),
        .WData2  (a_wdata[2]),
        .WE      (WE),
        .Grant   (Grant),
        .Ack     (Ack),
        .Error   (Error),
        .RData   (RData),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .MemWE   (MemWE),
        .MemReq  (MemReq),
        .MemAck  (MemAck),
        .MemRData(MemRData)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = -1;
        m_last   = 2;
        m_waited = 0;
        m_rel    = 0;
        m_ack    = 0;
        m_err    = 0;
        m_rdata  = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 0;
        m_memreq = 0;
    endtask

    task automatic model_edge();
        bit found;
        int k;
        found = 0;
        case (m_phase)
            0: begin
                for (int i = 1; i <= 3; i++) begin
                    k = (m_last + i) % 3;
                    if (!found && Req[k]) begin
                        found    = 1;
                        m_owner  = k;
                        m_last   = k;
                        m_addr   = a_addr[k];
                        m_wdata  = a_wdata[k];
                        m_we     = WE[k];
                        m_memreq = 1;
                        m_waited = 0;
                        m_phase  = 1;
                    end
                end
            end
            1: begin
                m_waited++;
                if (MemAck) begin
                    m_rdata  = MemRData;
                    m_ack    = 1;
                    m_memreq = 0;
                    m_phase  = 2;
                    m_rel    = 2;
                end else if (m_waited == TMO) begin
                    m_ack    = 1;
                    m_err    = 1;
                    m_memreq = 0;
                    m_phase  = 2;
                    m_rel    = 2;
                end
            end
            default: begin
                m_ack   = 0;
                m_err   = 0;
                m_owner = -1;
                m_rel--;
                if (m_rel == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic [2:0] g;
        g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        check("grant",  64'(Grant),    64'(g));
        check("ack",    64'(Ack),      m_ack ? 64'(g) : 64'd0);
        check("error",  64'(Error),    64'(m_err));
        check("rdata",  64'(RData),    64'(m_rdata));
        check("memreq", 64'(MemReq),   64'(m_memreq));
        check("onehot", 64'($countones(Grant) <= 1), 64'd1);
        if (m_memreq) begin
            check("memaddr",  64'(MemAddr),  64'(m_addr));
            check("memwdata", 64'(MemWData), 64'(m_wdata));
            check("memwe",    64'(MemWE),    64'(m_we));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        check_all();
        @(negedge Clock);
    endtask

    task automatic pulse_reset();
        #1 Reset = 1'b1;
        #1;
        check("rst_memreq", 64'(MemReq), 64'd0);
        check("rst_grant",  64'(Grant),  64'd0);
        check("rst_ack",    64'(Ack),    64'd0);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic finish_txn();
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        step();
        step();
    endtask

    logic [2:0] seq [4];

    initial begin
        Reset    = 1'b1;
        Req      = 3'b000;
        WE       = 3'b000;
        MemAck   = 1'b0;
        MemRData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            a_addr[i]  = 16'h0;
            a_wdata[i] = 32'h0;
        end
        model_reset();
        repeat (2) @(negedge Clock);
        check("rst_grant",  64'(Grant),    64'd0);
        check("rst_ack",    64'(Ack),      64'd0);
        check("rst_error",  64'(Error),    64'd0);
        check("rst_rdata",  64'(RData),    64'd0);
        check("rst_addr",   64'(MemAddr),  64'd0);
        check("rst_wdata",  64'(MemWData), 64'd0);
        check("rst_we",     64'(MemWE),    64'd0);
        check("rst_memreq", 64'(MemReq),   64'd0);
        Reset = 1'b0;

        // single read
        Req       = 3'b001;
        a_addr[0] = 16'h0040;
        step();
        check("rd_grant", 64'(Grant),   64'd1);
        check("rd_addr",  64'(MemAddr), 64'h40);
        check("rd_we",    64'(MemWE),   64'd0);
        MemAck   = 1'b1;
        MemRData = 32'hDEADBEEF;
        step();
        check("rd_ack",   64'(Ack),    64'd1);
        check("rd_rdata", 64'(RData),  64'hDEADBEEF);
        check("rd_mreq",  64'(MemReq), 64'd0);
        MemAck = 1'b0;
        Req    = 3'b000;
        step();
        check("rd_gnt0", 64'(Grant), 64'd0);
        check("rd_ack0", 64'(Ack),   64'd0);
        step();

        // fairness from reset
        pulse_reset();
        seq[0] = 3'b001;
        seq[1] = 3'b010;
        seq[2] = 3'b100;
        seq[3] = 3'b001;
        Req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            step();
            check("rr_grant", 64'(Grant), 64'(seq[t]));
            finish_txn();
        end
        Req = 3'b000;

        // write, address changed while busy
        Req        = 3'b100;
        WE         = 3'b100;
        a_addr[2]  = 16'h1234;
        a_wdata[2] = 32'h0000CAFE;
        step();
        a_addr[2]  = 16'h5555;
        a_wdata[2] = 32'h0BADF00D;
        WE         = 3'b000;
        step();
        step();
        check("wr_addr",  64'(MemAddr),  64'h1234);
        check("wr_wdata", 64'(MemWData), 64'h0000CAFE);
        check("wr_we",    64'(MemWE),    64'd1);
        MemAck = 1'b1;
        step();
        check("wr_ack", 64'(Ack), 64'b100);
        MemAck = 1'b0;
        Req    = 3'b000;
        step();
        step();

        // timeout with no MemAck
        Req      = 3'b001;
        MemRData = 32'h11111111;
        step();
        for (int i = 0; i < TMO; i++) step();
        check("to_ack",    64'(Ack),    64'd1);
        check("to_err",    64'(Error),  64'd1);
        check("to_rdata",  64'(RData),  64'hDEADBEEF);
        check("to_memreq", 64'(MemReq), 64'd0);
        step();
        check("to_err0", 64'(Error), 64'd0);
        step();

        // MemAck on the last allowed cycle wins over the timeout
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        MemAck   = 1'b1;
        MemRData = 32'h12345678;
        step();
        check("tl_ack",   64'(Ack),   64'd1);
        check("tl_err",   64'(Error), 64'd0);
        check("tl_rdata", 64'(RData), 64'h12345678);
        MemAck = 1'b0;
        Req    = 3'b000;
        step();
        step();

        // async reset mid-transaction
        Req = 3'b100;
        step();
        step();
        pulse_reset();
        Req = 3'b010;
        step();
        check("ar_grant", 64'(Grant), 64'b010);
        finish_txn();
        Req = 3'b000;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            Req = 3'($urandom);
            WE  = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                a_addr[i]  = 16'($urandom);
                a_wdata[i] = $urandom;
            end
            MemRData = $urandom;
            if (m_phase == 1) MemAck = ($urandom % 5) == 0;
            else              MemAck = ($urandom % 8) == 0;
            if (($urandom % 400) == 0) pulse_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
